smp8_sequencer: RTL and testbench
=================================

// Module: smp8_sequencer
// PURPOSE
//  Multi-cycle fetch/decode/execute sequencer for the SMP8 core. It fetches the opcode byte, and for
//  address-class ops also an operand byte, over a req/ready memory port. It drives op[3:0] to the
//  combinational decoder and turns the decoder's level outputs into single-cycle datapath strobes.
//  It owns the PC, IR and AR registers and the memory-port arbitration between fetch and data access.
// PARAMETERS
//  AW        8    address width (PC, AR, mem_addr)
//  RESET_PC  0    PC value loaded on reset
//  MAX_WAIT  15   max cycles mem_req may stay unacknowledged before bus_err (>=1)
// PORTS
//  clk        in   1   rising-edge clock
//  rst_n      in   1   asynchronous active-low reset
//  run        in   1   1 = execute; 0 = stop at the next FETCH boundary
//  mem_req    out  1   memory access request, held until mem_ready
//  mem_we     out  1   1 = write (STAC data phase only)
//  mem_addr   out  AW  access address
//  mem_rdata  in   8   read data, valid when mem_ready=1
//  mem_ready  in   1   access complete this cycle
//  op         out  4   IR[7:4], to the decoder
//  nop,load,store,mva,mvr,jump  in  1 each  decoder outputs (jump already zero-qualified)
//  exec_en    out  1   1-cycle strobe: datapath commits ALU/MVAC/MOVR per decoder outputs
//  acc_ld     out  1   1-cycle strobe: ACC <= mdr (LDAC)
//  mdr        out  8   last read data byte
//  pc         out  AW  program counter
//  busy       out  1   sequencer not in IDLE
//  bus_err    out  1   sticky: memory timeout; sequencer parked in IDLE
// BEHAVIOUR
//  Reset: state=IDLE, pc=RESET_PC, IR=0 (op=0), AR=0, mdr=0; all strobes, mem_req, mem_we,
//   busy and bus_err are 0.
//  States: IDLE, FETCH, DECODE, OPERAND, MEMACC, EXEC.
//  IDLE: if run && !bus_err -> FETCH.
//  FETCH: mem_req=1, mem_addr=pc. On mem_ready: IR<=mem_rdata, pc<=pc+1 (mod 2^AW) -> DECODE.
//  DECODE (1 cycle, decoder output settles): if op in {1,2,5,6,7} -> OPERAND, else -> EXEC.
//  OPERAND: mem_req=1, mem_addr=pc. On mem_ready: AR<=mem_rdata, pc<=pc+1.
//   If op in {1,2} -> MEMACC, else -> EXEC.
//  MEMACC: mem_req=1, mem_addr=AR, mem_we=store. On mem_ready: for a read, mdr<=mem_rdata -> EXEC.
//  EXEC (1 cycle):
//   - jump=1: pc<=AR. JMPZ/JPNZ not taken: pc unchanged.
//   - load: acc_ld=1.
//   - nop=0 and load=0: exec_en=1.
//   - next state = run ? FETCH : IDLE.
//   - store is finished in MEMACC; in EXEC it drives no strobe.
//  mem_req/mem_addr/mem_we stay stable while waiting. Never more than one access outstanding.
//  Wait counter clears on each new request. When it reaches MAX_WAIT without mem_ready:
//   bus_err<=1, mem_req drops, -> IDLE. Only reset clears bus_err.
//  run deasserting mid-instruction: the instruction completes and the sequencer stops before the
//   next FETCH. busy=0 only in IDLE.
//  Latency with zero-wait memory: 3 cycles for ALU/NOP/MOVR/MVAC, 4 for JUMP class,
//   5 for LDAC/STAC.
//  PC wraps 2^AW-1 -> 0 silently. mem_ready is ignored when mem_req=0.
//  Reset asserted mid-operation: immediate return to reset values; a pending access is dropped.
// TESTING
//  1. Reset; run=1, zero-wait mem, mem[0]=8'h80 (ADD).
//     -> FETCH at addr 0, exec_en in cycle 3, pc=1, next fetch at addr 1.
//  2. mem[0..1]=8'h10,8'h40, mem[0x40]=8'hA5.
//     -> reads at 0, 1, 0x40; acc_ld pulse with mdr=8'hA5; pc=2.
//  3. STAC: mem[0..1]=8'h20,8'h33.
//     -> one write cycle, mem_we=1, mem_addr=8'h33; no exec_en; pc=2.
//  4. JMPZ 8'h60, zero=1 then zero=0.
//     -> pc=8'h60 when taken; pc=2 when not taken.
//  5. mem_ready held 0 for MAX_WAIT cycles in FETCH.
//     -> bus_err=1, mem_req=0, busy=0; stays in IDLE with run=1 until rst_n low.
//  6. pc=8'hFF fetching NOP -> pc wraps to 8'h00. run dropped during MEMACC -> instruction
//     completes, then busy=0. rst_n pulsed mid-OPERAND -> pc=RESET_PC, mem_req=0 immediately.

Source files
------------

// File: rtl/smp8_mem_if.sv
// SMP8 memory port: one outstanding request, held until ready.
interface smp8_mem_if #(
    parameter int unsigned AW = 8
) ();
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [7:0]    rdata;
    logic          ready;

    modport master (output req, output we, output addr, input rdata, input ready);
    modport slave  (input req, input we, input addr, output rdata, output ready);
endinterface

// File: rtl/smp8_sequencer.sv
// SMP8 fetch/decode/execute sequencer: owns PC/IR/AR, arbitrates the memory port between
// instruction fetch and data access, and turns decoder levels into one-cycle strobes.
module smp8_sequencer #(
    parameter int unsigned AW       = 8,
    parameter int unsigned RESET_PC = 0,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_run,
    smp8_mem_if.master    mem,
    output logic [3:0]    o_op,
    input  logic          i_nop,
    input  logic          i_load,
    input  logic          i_store,
    input  logic          i_mva,
    input  logic          i_mvr,
    input  logic          i_jump,
    output logic          o_exec_en,
    output logic          o_acc_ld,
    output logic [7:0]    o_mdr,
    output logic [AW-1:0] o_pc,
    output logic          o_busy,
    output logic          o_bus_err
);
    localparam int unsigned WW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);

    typedef enum logic [2:0] {
        StIdle, StFetch, StDecode, StOperand, StMemacc, StExec
    } state_t;

    state_t        r_state;
    state_t        w_state_d;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_ar;
    logic [7:0]    r_ir;
    logic [7:0]    r_mdr;
    logic [WW-1:0] r_wait;
    logic          r_bus_err;

    logic          w_req;
    logic          w_done;
    logic          w_timeout;
    logic          w_has_operand;
    logic          w_mem_op;
    logic          w_unused;

    assign w_req     = (r_state == StFetch) || (r_state == StOperand) || (r_state == StMemacc);
    assign w_done    = w_req && mem.ready;
    assign w_timeout = w_req && !mem.ready && (r_wait == WW'(MAX_WAIT - 1));

    // LDAC/STAC and the three jump opcodes carry an address byte
    assign w_has_operand = (o_op == 4'd1) || (o_op == 4'd2) || (o_op == 4'd5) ||
                           (o_op == 4'd6) || (o_op == 4'd7);
    assign w_mem_op      = (o_op == 4'd1) || (o_op == 4'd2);

    // MVAC/MOVR only steer the datapath; the opcode low nibble is unused by this core
    assign w_unused = ^{i_mva, i_mvr, r_ir[3:0]};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:    if (i_run && !r_bus_err) w_state_d = StFetch;
            StFetch: begin
                if (w_done)         w_state_d = StDecode;
                else if (w_timeout) w_state_d = StIdle;
            end
            StDecode:  w_state_d = w_has_operand ? StOperand : StExec;
            StOperand: begin
                if (w_done)         w_state_d = w_mem_op ? StMemacc : StExec;
                else if (w_timeout) w_state_d = StIdle;
            end
            StMemacc: begin
                if (w_done)         w_state_d = StExec;
                else if (w_timeout) w_state_d = StIdle;
            end
            StExec:    w_state_d = i_run ? StFetch : StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pc      <= AW'(RESET_PC);
            r_ar      <= '0;
            r_ir      <= '0;
            r_mdr     <= '0;
            r_wait    <= '0;
            r_bus_err <= 1'b0;
        end else begin
            // Counts unacknowledged cycles of the current request only
            if (w_req && !mem.ready) r_wait <= r_wait + WW'(1);
            else                     r_wait <= '0;
            if (w_timeout) r_bus_err <= 1'b1;
            case (r_state)
                StFetch: if (mem.ready) begin
                    r_ir <= mem.rdata;
                    r_pc <= r_pc + AW'(1);
                end
                StOperand: if (mem.ready) begin
                    r_ar <= AW'(mem.rdata);
                    r_pc <= r_pc + AW'(1);
                end
                StMemacc: if (mem.ready && !i_store) r_mdr <= mem.rdata;
                StExec:   if (i_jump) r_pc <= r_ar;
                default: ;
            endcase
        end
    end

    always_comb begin
        mem.req   = w_req;
        mem.addr  = (r_state == StMemacc) ? r_ar : r_pc;
        mem.we    = (r_state == StMemacc) && i_store;
        o_op      = r_ir[7:4];
        o_exec_en = (r_state == StExec) && !i_nop && !i_load && !i_store;
        o_acc_ld  = (r_state == StExec) && i_load;
        o_mdr     = r_mdr;
        o_pc      = r_pc;
        o_busy    = (r_state != StIdle);
        o_bus_err = r_bus_err;
    end
endmodule

// File: tb/tb_smp8_sequencer.sv
// Scoreboard bench for smp8_sequencer: expected bus accesses and strobes are queued as each
// program is loaded and retired by a negedge monitor.
module tb_smp8_sequencer;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       run = 1'b0;
    logic       stall = 1'b0;
    logic       zero = 1'b0;
    logic [3:0] op;
    logic       nop, load, store, mva, mvr, jump;
    logic       exec_en, acc_ld, busy, bus_err;
    logic [7:0] mdr, pc;
    logic [7:0] mem_arr [256];

    int n_chk = 0;
    int n_bad = 0;
    int n_wr  = 0;

    typedef struct packed { logic we; logic [7:0] addr; } acc_t;
    typedef struct packed { logic ex; logic ld; logic [7:0] mdr; } strb_t;
    acc_t  acc_q  [$];
    strb_t strb_q [$];

    smp8_mem_if #(.AW(8)) bus ();

    smp8_sequencer #(.AW(8), .RESET_PC(0), .MAX_WAIT(15)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_run(run), .mem(bus), .o_op(op),
        .i_nop(nop), .i_load(load), .i_store(store), .i_mva(mva), .i_mvr(mvr), .i_jump(jump),
        .o_exec_en(exec_en), .o_acc_ld(acc_ld), .o_mdr(mdr), .o_pc(pc),
        .o_busy(busy), .o_bus_err(bus_err)
    );

    always #5 clk = ~clk;

    assign bus.rdata = mem_arr[bus.addr];
    assign bus.ready = bus.req && !stall;

    // Reference SMP8 decoder: NOP LDAC STAC MVAC MOVR JUMP JMPZ JPNZ, then ALU ops
    always_comb begin
        nop   = (op == 4'd0);
        load  = (op == 4'd1);
        store = (op == 4'd2);
        mva   = (op == 4'd3);
        mvr   = (op == 4'd4);
        jump  = (op == 4'd5) || ((op == 4'd6) && zero) || ((op == 4'd7) && !zero);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        acc_t  ea;
        strb_t es;
        if (bus.req && bus.ready) begin
            if (bus.we) n_wr++;
            if (acc_q.size() == 0) begin
                check_val("acc_unexpected", {23'b0, bus.we, bus.addr}, 32'hFFFF_FFFF);
            end else begin
                ea = acc_q.pop_front();
                check_val("acc", {23'b0, bus.we, bus.addr}, {23'b0, ea.we, ea.addr});
            end
        end
        if (exec_en || acc_ld) begin
            if (strb_q.size() == 0) begin
                check_val("strobe_unexpected", {22'b0, exec_en, acc_ld, mdr}, 32'hFFFF_FFFF);
            end else begin
                es = strb_q.pop_front();
                check_val("strobe", {22'b0, exec_en, acc_ld, mdr}, {22'b0, es.ex, es.ld, es.mdr});
            end
        end
    end

    task automatic push_acc(input logic we, input logic [7:0] addr);
        acc_t a;
        a.we = we;
        a.addr = addr;
        acc_q.push_back(a);
    endtask

    task automatic push_strb(input logic ex, input logic ld, input logic [7:0] d);
        strb_t s;
        s.ex = ex;
        s.ld = ld;
        s.mdr = d;
        strb_q.push_back(s);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        run = 1'b0;
        stall = 1'b0;
        n_wr = 0;
        for (int i = 0; i < 256; i++) mem_arr[i] = 8'h00;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        check_val(tag, {31'b0, busy}, 32'd0);
    endtask

    // Executes exactly one instruction: run drops once the fetch handshake is seen
    task automatic run_one(input string tag);
        int n = 0;
        @(negedge clk);
        run = 1'b1;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.req && bus.ready) && n < 50);
        run = 1'b0;
        wait_idle(tag, 50);
    endtask

    task automatic check_queues(input string tag);
        check_val({tag, "_accq"}, acc_q.size(), 0);
        check_val({tag, "_strbq"}, strb_q.size(), 0);
    endtask

    initial begin
        int n;
        int req_cyc;

        // Reset values
        do_reset();
        check_val("rst_busy", {31'b0, busy}, 0);
        check_val("rst_req", {31'b0, bus.req}, 0);
        check_val("rst_pc", {24'b0, pc}, 0);
        check_val("rst_op", {28'b0, op}, 0);
        check_val("rst_mdr", {24'b0, mdr}, 0);
        check_val("rst_err", {29'b0, bus_err, exec_en, acc_ld}, 0);

        // 1: ADD then NOP, cycle-exact
        mem_arr[0] = 8'h80;
        push_acc(1'b0, 8'h00);
        push_acc(1'b0, 8'h01);
        push_strb(1'b1, 1'b0, 8'h00);
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        check_val("t1_fetch0", {23'b0, bus.req, bus.addr}, {23'b0, 1'b1, 8'h00});
        @(negedge clk);
        check_val("t1_decode_pc", {24'b0, pc}, 1);
        @(negedge clk);
        check_val("t1_exec_c3", {31'b0, exec_en}, 1);
        @(negedge clk);
        check_val("t1_fetch1", {23'b0, bus.req, bus.addr}, {23'b0, 1'b1, 8'h01});
        run = 1'b0;
        wait_idle("t1_idle", 20);
        check_val("t1_pc", {24'b0, pc}, 2);
        check_queues("t1");

        // 2: LDAC 0x40
        do_reset();
        mem_arr[0] = 8'h10; mem_arr[1] = 8'h40; mem_arr[8'h40] = 8'hA5;
        push_acc(1'b0, 8'h00); push_acc(1'b0, 8'h01); push_acc(1'b0, 8'h40);
        push_strb(1'b0, 1'b1, 8'hA5);
        run_one("t2_idle");
        check_val("t2_pc", {24'b0, pc}, 2);
        check_val("t2_mdr", {24'b0, mdr}, 32'hA5);
        check_queues("t2");

        // 3: STAC 0x33
        do_reset();
        mem_arr[0] = 8'h20; mem_arr[1] = 8'h33;
        push_acc(1'b0, 8'h00); push_acc(1'b0, 8'h01); push_acc(1'b1, 8'h33);
        run_one("t3_idle");
        check_val("t3_writes", n_wr, 1);
        check_val("t3_pc", {24'b0, pc}, 2);
        check_queues("t3");

        // 4: JMPZ 0x60, taken then not taken
        for (int z = 1; z >= 0; z--) begin
            do_reset();
            zero = z[0];
            mem_arr[0] = 8'h60; mem_arr[1] = 8'h60;
            push_acc(1'b0, 8'h00); push_acc(1'b0, 8'h01);
            push_strb(1'b1, 1'b0, 8'h00);
            run_one("t4_idle");
            check_val("t4_pc", {24'b0, pc}, z[0] ? 32'h60 : 32'h2);
            check_queues("t4");
        end
        zero = 1'b0;

        // 5: fetch never acknowledged
        do_reset();
        mem_arr[0] = 8'h80;
        stall = 1'b1;
        @(negedge clk);
        run = 1'b1;
        n = 0;
        req_cyc = 0;
        do begin
            @(negedge clk);
            n++;
            if (bus.req) req_cyc++;
        end while (!bus_err && n < 100);
        check_val("t5_err", {31'b0, bus_err}, 1);
        check_val("t5_req_cycles", req_cyc, 15);
        check_val("t5_req_busy", {30'b0, bus.req, busy}, 0);
        stall = 1'b0;
        repeat (10) @(negedge clk);
        check_val("t5_parked", {29'b0, bus_err, bus.req, busy}, {29'b0, 3'b100});
        do_reset();
        check_val("t5_err_clr", {31'b0, bus_err}, 0);
        check_queues("t5");

        // 6a: JUMP to 0xFF, then NOP at 0xFF wraps pc
        do_reset();
        mem_arr[0] = 8'h50; mem_arr[1] = 8'hFF; mem_arr[8'hFF] = 8'h00;
        push_acc(1'b0, 8'h00); push_acc(1'b0, 8'h01);
        push_strb(1'b1, 1'b0, 8'h00);
        run_one("t6a_idle0");
        check_val("t6a_pc_ff", {24'b0, pc}, 32'hFF);
        push_acc(1'b0, 8'hFF);
        run_one("t6a_idle1");
        check_val("t6a_pc_wrap", {24'b0, pc}, 0);
        check_queues("t6a");

        // 6b: run drops during MEMACC
        do_reset();
        mem_arr[0] = 8'h10; mem_arr[1] = 8'h40; mem_arr[8'h40] = 8'h5A;
        push_acc(1'b0, 8'h00); push_acc(1'b0, 8'h01); push_acc(1'b0, 8'h40);
        push_strb(1'b0, 1'b1, 8'h5A);
        @(negedge clk);
        run = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.req && bus.addr == 8'h40) && n < 50);
        check_val("t6b_memacc", {31'b0, bus.req}, 1);
        run = 1'b0;
        wait_idle("t6b_idle", 20);
        check_val("t6b_pc", {24'b0, pc}, 2);
        check_queues("t6b");

        // 6c: reset pulsed while OPERAND is stalled
        do_reset();
        mem_arr[0] = 8'h10; mem_arr[1] = 8'h40;
        push_acc(1'b0, 8'h00);
        @(negedge clk);
        run = 1'b1;
        @(negedge clk);
        @(negedge clk);
        stall = 1'b1;
        repeat (2) @(negedge clk);
        check_val("t6c_operand", {23'b0, bus.req, bus.addr}, {23'b0, 1'b1, 8'h01});
        check_val("t6c_pc_pre", {24'b0, pc}, 1);
        rst_n = 1'b0;
        #1;
        check_val("t6c_rst_req", {30'b0, bus.req, busy}, 0);
        check_val("t6c_rst_pc", {24'b0, pc}, 0);
        check_val("t6c_rst_op", {28'b0, op}, 0);
        @(negedge clk);
        run = 1'b0;
        stall = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check_queues("t6c");

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog expired");
    end
endmodule
